stream_rr_arbiter: RTL

- Merges N stb/ack output streams from C2CHIP-generated processes into one stb/ack stream.
- Typical use: several producer cores sharing a single consumer or an output pin.
- Round-robin fairness; a granted requester may hold the output for up to BURST consecutive words before the grant rotates.
- The output word and its source index are registered, so no combinational path runs from in_stb to out_stb.

---
 rtl/stream_arb_pkg.sv | 43 ++++
 rtl/rr_priority_picker.sv | 27 ++
 rtl/stream_rr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and the rotated-priority search used by the stream arbiter.
// rr_pick works on a request vector of up to RR_MAX_N bits; callers zero-extend.
package stream_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_N = 64;
    localparam int unsigned RR_IDX_W = 6;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req searching ptr, ptr+1, ... n-1, 0, ... ptr-1.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         ptr,
        input int unsigned         n
    );
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        k   = 0;
        for (int unsigned off = 0; off < RR_MAX_N; off++) begin
            if (off < n) begin
                k = ptr + off;
                if (k >= n) begin
                    k = k - n;
                end
                if (!res.valid && req[k[RR_IDX_W-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = k[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotated-priority encoder: returns the first requesting index at or
// after ptr (wrapping modulo N_INPUTS). N_INPUTS must not exceed RR_MAX_N.
module rr_priority_picker
    import stream_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned SRC_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic [N_INPUTS-1:0] req,
    input  logic [SRC_W-1:0]    ptr,
    output logic [SRC_W-1:0]    grant,
    output logic                any
);

    logic [RR_MAX_N-1:0] req_ext;
    rr_pick_t            pick;

    // Zero-extend the request vector and run the rotated search
    always_comb begin
        req_ext                 = '0;
        req_ext[N_INPUTS-1:0]   = req;
        pick                    = rr_pick(req_ext, 32'(ptr), N_INPUTS);
        grant                   = SRC_W'(pick.idx);
        any                     = pick.valid;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of N_INPUTS stb/ack streams into one registered stb/ack stream.
// A granted requester may keep the output for up to BURST consecutive words; the
// output word, its source index and the input acks are all registered.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BURST    = 1,
    parameter int unsigned SRC_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]       in_stb,
    output logic [N_INPUTS-1:0]       in_ack,
    output logic [WIDTH-1:0]          out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_stb,
    input  logic                      out_ack
);

    localparam int unsigned      CNT_W    = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_INPUTS - 1);

    logic [WIDTH-1:0]    in_words [N_INPUTS];

    arb_state_e          state_q, state_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [SRC_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic                out_stb_q, out_stb_d;
    logic [N_INPUTS-1:0] in_ack_q, in_ack_d;

    logic [SRC_W-1:0]    rr_idx;
    logic                rr_any;
    logic                burst_cont;
    logic [SRC_W-1:0]    win;
    logic [CNT_W-1:0]    cnt_next;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_slice
        assign in_words[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_priority_picker #(
        .N_INPUTS (N_INPUTS),
        .SRC_W    (SRC_W)
    ) u_picker (
        .req   (in_stb),
        .ptr   (ptr_q),
        .grant (rr_idx),
        .any   (rr_any)
    );

    // Winner: the burst owner keeps the grant while it still requests and has budget left
    always_comb begin
        burst_cont = (cnt_q != '0) && (cnt_q < BURST_C) &&
                     ((in_stb & (N_INPUTS'(1) << last_q)) != '0);
        win        = burst_cont ? last_q : rr_idx;
        cnt_next   = burst_cont ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
    end

    // Next state, grant bookkeeping and output register updates
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        out_stb_d  = out_stb_q;
        in_ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    out_data_d = in_words[win];
                    out_src_d  = win;
                    out_stb_d  = 1'b1;
                    in_ack_d   = N_INPUTS'(1) << win;
                    last_d     = win;
                    if (cnt_next == BURST_C) begin
                        // Budget spent: rotate past the owner and start a fresh burst
                        ptr_d = (win == LAST_IDX) ? '0 : (win + SRC_W'(1));
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_next;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
            out_stb_q  <= 1'b0;
            in_ack_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            out_stb_q  <= out_stb_d;
            in_ack_q   <= in_ack_d;
        end
    end

    assign in_ack   = in_ack_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;
    assign out_stb  = out_stb_q;

endmodule
